weight_sram_burst: RTL and testbench

- Parametrised successor of the fixed 80-bit weight SRAM model.
- Storage is DEPTH words, each WEIGHT_PIXEL_NUM weights of WEIGHT_WIDTH bits, with a per-weight write mask.
- Adds a burst read engine that streams LEN consecutive words out on a valid/ready interface with backpressure.
- Sits between the weight loader (write side) and the PE array weight fetch (read side) of the LeNet accelerator.

---
 rtl/weight_sram_pkg.sv | 14 +
 rtl/sram_1r1w_mask.sv | 43 ++++
 rtl/weight_sram_burst.sv | 176 +++++++++++++++++
 tb/tb_weight_sram_burst.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/weight_sram_pkg.sv
// Shared constants and FSM state type for the LeNet weight SRAM with burst read engine.
package weight_sram_pkg;

  localparam int WEIGHT_WIDTH     = 4;
  localparam int WEIGHT_PIXEL_NUM = 20;
  localparam int DW               = WEIGHT_WIDTH * WEIGHT_PIXEL_NUM;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } burst_state_e;

endpackage

// File: rtl/sram_1r1w_mask.sv
// Single-read single-write storage array: per-slice masked write, registered 1-cycle read.
module sram_1r1w_mask #(
  parameter  int DW    = 80,
  parameter  int DEPTH = 20250,
  parameter  int NB    = 20,
  localparam int AW    = $clog2(DEPTH),
  localparam int SW    = DW / NB
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [NB-1:0] wmask_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  // NOTE: the array and its read register carry no reset; resetting a RAM
  // would force it into flops and contents must survive rst_n anyway.
  // Both the read and the write use the pre-edge value of mem_q, so a
  // same-address read in the write cycle returns the old word.
  always_ff @(posedge clk) begin
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
    if (we_i && (waddr_i <= LAST_ADDR)) begin
      for (int i = 0; i < NB; i++) begin
        if (wmask_i[i]) begin
          mem_q[waddr_i][i*SW +: SW] <= wdata_i[i*SW +: SW];
        end
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/weight_sram_burst.sv
// Weight SRAM with a burst read engine streaming LEN words through a 2-entry
// output FIFO on a valid/ready interface.
module weight_sram_burst
  import weight_sram_pkg::*;
#(
  parameter int DEPTH = 20250,
  parameter int AW    = $clog2(DEPTH),
  parameter int LW    = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        csb,
  input  logic                        wsb,
  input  logic [WEIGHT_PIXEL_NUM-1:0] wmask,
  input  logic [AW-1:0]               waddr,
  input  logic [DW-1:0]               wdata,
  input  logic                        burst_start,
  input  logic [AW-1:0]               burst_addr,
  input  logic [LW-1:0]               burst_len,
  output logic                        burst_busy,
  output logic                        burst_done,
  output logic [DW-1:0]               rdata,
  output logic                        rvalid,
  input  logic                        rready
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  burst_state_e  state_q;
  logic [AW-1:0] addr_q;
  logic [LW-1:0] remaining_q;
  logic [1:0]    inflight_q;
  logic [1:0]    fifo_count_q;
  logic [1:0]    fifo_count_d;
  logic [DW-1:0] fifo_q [2];
  logic          wr_ptr_q;
  logic          rd_ptr_q;
  logic          burst_busy_q;
  logic          burst_done_q;

  logic          pop;
  logic          push;
  logic          issue;
  logic          sram_we;
  logic [2:0]    occupancy;
  logic [AW-1:0] addr_inc;
  logic [DW-1:0] sram_rdata;

  assign rvalid  = (fifo_count_q != 2'd0);
  assign pop     = rvalid && rready;
  // The array output is valid exactly one cycle after issue.
  assign push    = (inflight_q != 2'd0);
  assign sram_we = !csb && !wsb;

  // A word leaving this cycle frees its slot in time for the issued read to
  // land, which is what sustains one word per cycle without overflowing.
  assign occupancy = {1'b0, fifo_count_q} + {1'b0, inflight_q} - {2'b0, pop};
  assign issue     = (state_q == ISSUE) && !csb && (occupancy < 3'd2);

  // DEPTH need not be a power of two, so wrap on an explicit compare.
  assign addr_inc = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    fifo_count_d = fifo_count_q;
    if (push && !pop) begin
      fifo_count_d = fifo_count_q + 2'd1;
    end else if (pop && !push) begin
      fifo_count_d = fifo_count_q - 2'd1;
    end
  end

  sram_1r1w_mask #(
    .DW   (DW),
    .DEPTH(DEPTH),
    .NB   (WEIGHT_PIXEL_NUM)
  ) u_sram (
    .clk    (clk),
    .we_i   (sram_we),
    .wmask_i(wmask),
    .waddr_i(waddr),
    .wdata_i(wdata),
    .re_i   (issue),
    .raddr_i(addr_q),
    .rdata_o(sram_rdata)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      remaining_q  <= '0;
      inflight_q   <= '0;
      fifo_count_q <= '0;
      fifo_q[0]    <= '0;
      fifo_q[1]    <= '0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      burst_busy_q <= 1'b0;
      burst_done_q <= 1'b0;
    end else begin
      burst_done_q <= 1'b0;
      inflight_q   <= {1'b0, issue};
      fifo_count_q <= fifo_count_d;
      if (push) begin
        fifo_q[wr_ptr_q] <= sram_rdata;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end

      case (state_q)
        IDLE: begin
          if (burst_start) begin
            if (burst_len == '0) begin
              burst_done_q <= 1'b1;
            end else begin
              addr_q       <= burst_addr;
              remaining_q  <= burst_len;
              burst_busy_q <= 1'b1;
              state_q      <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (issue) begin
            addr_q      <= addr_inc;
            remaining_q <= remaining_q - 1'b1;
            if (remaining_q == LW'(1)) begin
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // Last word leaves now: nothing in flight and a single entry left.
          if ((inflight_q == 2'd0) && (fifo_count_q == 2'd1) && pop) begin
            burst_done_q <= 1'b1;
            burst_busy_q <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign burst_busy = burst_busy_q;
  assign burst_done = burst_done_q;

`ifdef SRAM_OUT_DELAY
`ifndef CYCLE_PERIOD
`define CYCLE_PERIOD 10
`endif
  assign #(`CYCLE_PERIOD * 0.3) rdata = fifo_q[rd_ptr_q];
`else
  assign rdata = fifo_q[rd_ptr_q];
`endif

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rst_n && (state_q == IDLE) && burst_start && (burst_len != '0)) begin
      assert (burst_addr <= LAST_ADDR)
        else $error("weight_sram_burst: burst_addr %0d beyond DEPTH", burst_addr);
    end
    if (rst_n && push) begin
      assert ((fifo_count_q != 2'd2) || pop)
        else $error("weight_sram_burst: output FIFO overflow");
    end
  end
`endif

endmodule

// File: tb/tb_weight_sram_burst.sv
// Scoreboard bench for weight_sram_burst: a word-array reference model feeds an
// expectation queue that an independent monitor drains on each handshake.
module tb_weight_sram_burst;
  import weight_sram_pkg::*;

  localparam int DEPTH = 20250;
  localparam int AW    = $clog2(DEPTH);
  localparam int LW    = 16;
  localparam int NB    = WEIGHT_PIXEL_NUM;

  logic          clk;
  logic          rst_n;
  logic          csb;
  logic          wsb;
  logic [NB-1:0] wmask;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic          burst_start;
  logic [AW-1:0] burst_addr;
  logic [LW-1:0] burst_len;
  logic          burst_busy;
  logic          burst_done;
  logic [DW-1:0] rdata;
  logic          rvalid;
  logic          rready;

  typedef struct {
    logic [DW-1:0] data;
    bit            last;
  } exp_t;

  exp_t          exp_q[$];
  int            hs_cyc_q[$];
  logic [DW-1:0] model [DEPTH];
  int            checks;
  int            errors;
  int            done_seen;
  int            done_target;
  int            cyc;
  int            max_fifo;
  int            rr_mode;
  bit            done_pend;
  bit            prev_stall;
  logic [DW-1:0] prev_data;

  weight_sram_burst #(.DEPTH(DEPTH), .AW(AW), .LW(LW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .csb        (csb),
    .wsb        (wsb),
    .wmask      (wmask),
    .waddr      (waddr),
    .wdata      (wdata),
    .burst_start(burst_start),
    .burst_addr (burst_addr),
    .burst_len  (burst_len),
    .burst_busy (burst_busy),
    .burst_done (burst_done),
    .rdata      (rdata),
    .rvalid     (rvalid),
    .rready     (rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every handshake and polices the protocol.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_stall = 1'b0;
      done_pend  = 1'b0;
    end else begin
      cyc++;
      if (int'(dut.fifo_count_q) > max_fifo) max_fifo = int'(dut.fifo_count_q);
      if (done_pend) begin
        check("done_after_last", DW'(burst_done), DW'(1));
        check("busy_clear_with_done", DW'(burst_busy), DW'(0));
        done_pend = 1'b0;
      end
      if (burst_done) done_seen++;
      if (prev_stall) begin
        check("stall_rvalid_held", DW'(rvalid), DW'(1));
        check("stall_rdata_stable", rdata, prev_data);
      end
      if (rvalid && rready) begin
        check("word_expected", DW'(exp_q.size() != 0), DW'(1));
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("rdata", rdata, e.data);
          hs_cyc_q.push_back(cyc);
          if (e.last) done_pend = 1'b1;
        end
      end
      prev_stall = rvalid && !rready;
      prev_data  = rdata;
    end
  end

  // Consumer: 0 = always ready, 1 = 1,0,0,1 pattern, 2 = random.
  initial begin
    int ph;
    ph     = 0;
    rready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rr_mode)
        0: rready = 1'b1;
        1: begin
          rready = ((ph % 4) == 0) || ((ph % 4) == 3);
          ph++;
        end
        default: rready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // All stimulus tasks are entered and left one time unit after a rising edge.
  task automatic do_write(input int a, input logic [DW-1:0] d, input logic [NB-1:0] m);
    waddr = AW'(a);
    wdata = d;
    wmask = m;
    wsb   = 1'b0;
    @(posedge clk);
    #1;
    wsb = 1'b1;
    for (int w = 0; w < NB; w++) begin
      if (m[w]) model[a][w*WEIGHT_WIDTH +: WEIGHT_WIDTH] = d[w*WEIGHT_WIDTH +: WEIGHT_WIDTH];
    end
  endtask

  task automatic load_w(input int index, input logic [DW-1:0] word);
    do_write(index, word, '1);
  endtask

  task automatic dump(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) $display("model[%0d] = %h", i, model[i]);
  endtask

  task automatic start_burst(input int a, input int len, input bit push_model);
    int p;
    p = a;
    if (push_model) begin
      for (int i = 0; i < len; i++) begin
        exp_q.push_back('{data: model[p], last: (i == len - 1)});
        p = (p == DEPTH - 1) ? 0 : p + 1;
      end
    end
    done_target++;
    burst_addr  = AW'(a);
    burst_len   = LW'(len);
    burst_start = 1'b1;
    @(posedge clk);
    #1;
    burst_start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while ((done_seen < done_target) && (n < 3000)) begin
      @(negedge clk);
      #1;
      n++;
    end
    repeat (4) @(posedge clk);
    #1;
    check({name, "_done_count"}, DW'(done_seen), DW'(done_target));
    check({name, "_drained"}, DW'(exp_q.size()), DW'(0));
  endtask

  initial begin
    logic [DW-1:0] v;
    checks = 0; errors = 0; done_seen = 0; done_target = 0; cyc = 0; max_fifo = 0;
    rr_mode = 0; done_pend = 1'b0; prev_stall = 1'b0; prev_data = '0;
    rst_n = 1'b0; csb = 1'b0; wsb = 1'b1; wmask = '0; waddr = '0; wdata = '0;
    burst_start = 1'b0; burst_addr = '0; burst_len = '0;

    #12;
    check("reset_rvalid", DW'(rvalid), DW'(0));
    check("reset_busy", DW'(burst_busy), DW'(0));
    check("reset_done", DW'(burst_done), DW'(0));
    check("reset_rdata", rdata, '0);
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Masked write: only weight 0 of addr 5 cleared.
    do_write(5, '1, '1);
    do_write(5, '0, 20'h00001);
    exp_q.push_back('{data: 80'hFFFF_FFFF_FFFF_FFFF_FFF0, last: 1'b1});
    start_burst(5, 1, 1'b0);
    wait_done("masked");

    // Streaming at full rate.
    for (int i = 0; i < 10; i++) load_w(i, DW'(i));
    dump(0, 3);
    hs_cyc_q.delete();
    start_burst(0, 10, 1'b1);
    wait_done("stream");
    check("stream_words", DW'(hs_cyc_q.size()), DW'(10));
    if (hs_cyc_q.size() == 10) check("stream_contiguous", DW'(hs_cyc_q[9] - hs_cyc_q[0]), DW'(9));

    // Backpressure 1,0,0,1.
    rr_mode = 1;
    start_burst(0, 10, 1'b1);
    wait_done("backpressure");

    // Wrap across DEPTH-1 with an ignored second start.
    for (int i = DEPTH - 2; i < DEPTH; i++) load_w(i, DW'({$urandom(), $urandom(), $urandom()}));
    load_w(0, DW'({$urandom(), $urandom(), $urandom()}));
    load_w(1, DW'({$urandom(), $urandom(), $urandom()}));
    start_burst(DEPTH - 2, 4, 1'b1);
    burst_addr  = AW'(100);
    burst_len   = LW'(3);
    burst_start = 1'b1;
    @(posedge clk);
    #1;
    burst_start = 1'b0;
    wait_done("wrap_ignore");

    // Read-before-write at addr 7 in its issue cycle.
    rr_mode = 0;
    load_w(7, DW'(32'h0000_0777));
    load_w(8, DW'(32'h0000_0888));
    start_burst(7, 2, 1'b1);
    v = DW'({$urandom(), $urandom(), $urandom()});
    do_write(7, v, '1);
    wait_done("rbw_old");
    start_burst(7, 1, 1'b1);
    wait_done("rbw_new");

    // Asynchronous reset after three words of a ten-word burst.
    for (int i = 0; i < 10; i++) load_w(i, DW'(i + 16));
    hs_cyc_q.delete();
    start_burst(0, 10, 1'b1);
    for (int n = 0; (n < 200) && (hs_cyc_q.size() < 3); n++) @(negedge clk);
    check("reset_mid_reached", DW'(hs_cyc_q.size() >= 3), DW'(1));
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    done_target = done_seen;
    #1;
    check("midreset_rvalid", DW'(rvalid), DW'(0));
    check("midreset_busy", DW'(burst_busy), DW'(0));
    check("midreset_rdata", rdata, '0);
    #15 rst_n = 1'b1;
    @(posedge clk);
    #1;
    start_burst(0, 10, 1'b1);
    wait_done("after_reset");

    // Randomised bursts, writes and consumer, plus a zero-length burst.
    rr_mode = 2;
    for (int i = 0; i < 80; i++) load_w(i, DW'({$urandom(), $urandom(), $urandom()}));
    for (int k = 0; k < 10; k++) begin
      do_write($urandom_range(0, 79), DW'({$urandom(), $urandom(), $urandom()}), NB'($urandom()));
      start_burst($urandom_range(0, 70), $urandom_range(1, 8), 1'b1);
      wait_done("random");
    end
    start_burst(3, 0, 1'b1);
    wait_done("zero_len");

    check("fifo_bound", DW'(max_fifo > 2), DW'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
